// File: rtl/exec_sequencer.sv
// Multi-cycle Y86-64 execute-stage controller: drives a shared external ALU,
// captures valE, owns the condition codes and resolves cnd for cmovXX/jXX.
module exec_sequencer #(
  parameter int          WIDTH      = 64,
  parameter int          STACK_STEP = 8,
  parameter logic [2:0]  CC_RST     = 3'b001
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       icode,
  input  logic [3:0]       ifun,
  input  logic [WIDTH-1:0] valA,
  input  logic [WIDTH-1:0] valB,
  input  logic [WIDTH-1:0] valC,
  output logic [1:0]       alu_fn,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_res,
  input  logic             alu_of,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] valE,
  output logic             cnd,
  output logic [2:0]       cc,
  output logic             err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  localparam logic [1:0] FN_ADD = 2'd0;
  localparam logic [1:0] FN_SUB = 2'd1;

  state_t           state_q, state_d;
  logic [3:0]       icode_q, icode_d;
  logic [3:0]       ifun_q, ifun_d;
  logic [1:0]       alu_fn_q, alu_fn_d;
  logic [WIDTH-1:0] alu_a_q, alu_a_d;
  logic [WIDTH-1:0] alu_b_q, alu_b_d;
  logic [WIDTH-1:0] valE_q, valE_d;
  logic             cnd_q, cnd_d;
  logic             err_q, err_d;
  logic [2:0]       cc_q, cc_d;

  function automatic logic is_illegal(input logic [3:0] ic, input logic [3:0] fn);
    logic bad;
    bad = 1'b0;
    if (ic > 4'hB) begin
      bad = 1'b1;
    end else if ((ic == 4'h6) && (fn > 4'd3)) begin
      bad = 1'b1;
    end else if (((ic == 4'h2) || (ic == 4'h7)) && (fn > 4'd6)) begin
      bad = 1'b1;
    end else begin
      bad = 1'b0;
    end
    return bad;
  endfunction

  // cc is {OF,SF,ZF}
  function automatic logic cond_eval(input logic [3:0] fn, input logic [2:0] c);
    logic of_v, sf_v, zf_v, r;
    of_v = c[2];
    sf_v = c[1];
    zf_v = c[0];
    case (fn)
      4'd0:    r = 1'b1;
      4'd1:    r = (sf_v ^ of_v) | zf_v;
      4'd2:    r = sf_v ^ of_v;
      4'd3:    r = zf_v;
      4'd4:    r = ~zf_v;
      4'd5:    r = ~(sf_v ^ of_v);
      4'd6:    r = ~(sf_v ^ of_v) & ~zf_v;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  // Next-state, operand selection and result capture
  always_comb begin
    state_d  = state_q;
    icode_d  = icode_q;
    ifun_d   = ifun_q;
    alu_fn_d = alu_fn_q;
    alu_a_d  = alu_a_q;
    alu_b_d  = alu_b_q;
    valE_d   = valE_q;
    cnd_d    = cnd_q;
    err_d    = err_q;
    cc_d     = cc_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          state_d  = S_EXEC;
          icode_d  = icode;
          ifun_d   = ifun;
          alu_fn_d = FN_ADD;
          alu_a_d  = '0;
          alu_b_d  = '0;
          // Operands are registered at accept so they are stable throughout EXEC.
          if (!is_illegal(icode, ifun)) begin
            case (icode)
              4'h2: begin alu_fn_d = FN_ADD;    alu_a_d = valA;                alu_b_d = '0;   end
              4'h3: begin alu_fn_d = FN_ADD;    alu_a_d = valC;                alu_b_d = '0;   end
              4'h4,
              4'h5: begin alu_fn_d = FN_ADD;    alu_a_d = valC;                alu_b_d = valB; end
              4'h6: begin alu_fn_d = ifun[1:0]; alu_a_d = valA;                alu_b_d = valB; end
              4'h8,
              4'hA: begin alu_fn_d = FN_SUB;    alu_a_d = WIDTH'(STACK_STEP);  alu_b_d = valB; end
              4'h9,
              4'hB: begin alu_fn_d = FN_ADD;    alu_a_d = WIDTH'(STACK_STEP);  alu_b_d = valB; end
              default: begin alu_fn_d = FN_ADD; alu_a_d = '0;                  alu_b_d = '0;   end
            endcase
          end else begin
            alu_fn_d = FN_ADD;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_EXEC: begin
        state_d  = S_RESP;
        err_d    = is_illegal(icode_q, ifun_q);
        valE_d   = '0;
        cnd_d    = 1'b0;
        alu_fn_d = FN_ADD;
        alu_a_d  = '0;
        alu_b_d  = '0;
        if (!is_illegal(icode_q, ifun_q)) begin
          case (icode_q)
            4'h2, 4'h3, 4'h4, 4'h5, 4'h6,
            4'h8, 4'h9, 4'hA, 4'hB: valE_d = alu_res;
            default:                valE_d = '0;
          endcase
          // cnd sees cc_q, i.e. the flags before this instruction's update.
          if ((icode_q == 4'h2) || (icode_q == 4'h7)) begin
            cnd_d = cond_eval(ifun_q, cc_q);
          end else begin
            cnd_d = 1'b0;
          end
          if (icode_q == 4'h6) begin
            cc_d = {alu_of, alu_res[WIDTH-1], (alu_res == '0)};
          end else begin
            cc_d = cc_q;
          end
        end else begin
          cc_d = cc_q;
        end
      end
      S_RESP: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_RESP;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      icode_q  <= 4'h0;
      ifun_q   <= 4'h0;
      alu_fn_q <= 2'd0;
      alu_a_q  <= '0;
      alu_b_q  <= '0;
      valE_q   <= '0;
      cnd_q    <= 1'b0;
      err_q    <= 1'b0;
      cc_q     <= CC_RST;
    end else begin
      state_q  <= state_d;
      icode_q  <= icode_d;
      ifun_q   <= ifun_d;
      alu_fn_q <= alu_fn_d;
      alu_a_q  <= alu_a_d;
      alu_b_q  <= alu_b_d;
      valE_q   <= valE_d;
      cnd_q    <= cnd_d;
      err_q    <= err_d;
      cc_q     <= cc_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_RESP);
  assign alu_fn    = alu_fn_q;
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign valE      = valE_q;
  assign cnd       = cnd_q;
  assign err       = err_q;
  assign cc        = cc_q;

endmodule

// File: tb/tb_exec_sequencer.sv
// Directed bench for exec_sequencer with a behavioural shared ALU.
module tb_exec_sequencer;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  icode;
  logic [3:0]  ifun;
  logic [63:0] valA, valB, valC;
  logic [1:0]  alu_fn;
  logic [63:0] alu_a, alu_b, alu_res;
  logic        alu_of;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] valE;
  logic        cnd;
  logic [2:0]  cc;
  logic        err;

  int checks;
  int failures;

  exec_sequencer #(.WIDTH(64), .STACK_STEP(8), .CC_RST(3'b001)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .icode(icode), .ifun(ifun), .valA(valA), .valB(valB), .valC(valC),
    .alu_fn(alu_fn), .alu_a(alu_a), .alu_b(alu_b), .alu_res(alu_res),
    .alu_of(alu_of), .out_valid(out_valid), .out_ready(out_ready),
    .valE(valE), .cnd(cnd), .cc(cc), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Shared ALU: add, sub (b-a), and, xor with signed overflow
  always_comb begin
    alu_res = 64'd0;
    alu_of  = 1'b0;
    case (alu_fn)
      2'd0: begin alu_res = alu_a + alu_b; alu_of = (alu_a[63] == alu_b[63]) && (alu_res[63] != alu_a[63]); end
      2'd1: begin alu_res = alu_b - alu_a; alu_of = (alu_a[63] != alu_b[63]) && (alu_res[63] != alu_b[63]); end
      2'd2: alu_res = alu_a & alu_b;
      default: alu_res = alu_a ^ alu_b;
    endcase
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full instruction with out_ready=1; alu checks are done in EXEC
  task automatic run(input string tag, input logic [3:0] ic, input logic [3:0] fn,
                     input logic [63:0] a, input logic [63:0] b, input logic [63:0] c,
                     input bit chk_alu, input logic [1:0] e_fn, input logic [63:0] e_a,
                     input logic [63:0] e_b, input logic [63:0] e_valE, input logic e_cnd,
                     input logic e_err, input logic [2:0] e_cc);
    icode = ic; ifun = fn; valA = a; valB = b; valC = c; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    icode = 4'hF; ifun = 4'hF; valA = 64'hDEAD; valB = 64'hBEEF; valC = 64'hCAFE;
    chk({tag, ".exec_out_valid"}, out_valid, 1'b0);
    chk({tag, ".exec_in_ready"}, in_ready, 1'b0);
    if (chk_alu) begin
      chk({tag, ".alu_fn"}, alu_fn, e_fn);
      chk({tag, ".alu_a"}, alu_a, e_a);
      chk({tag, ".alu_b"}, alu_b, e_b);
    end
    tick();
    chk({tag, ".out_valid"}, out_valid, 1'b1);
    chk({tag, ".valE"}, valE, e_valE);
    chk({tag, ".cnd"}, cnd, e_cnd);
    chk({tag, ".err"}, err, e_err);
    chk({tag, ".cc"}, cc, e_cc);
    tick();
    chk({tag, ".back_idle"}, in_ready, 1'b1);
  endtask

  initial begin
    checks = 0; failures = 0;
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    icode = 4'h0; ifun = 4'h0; valA = 64'd0; valB = 64'd0; valC = 64'd0;
    tick(); tick();
    reset = 1'b0;
    chk("rst.in_ready", in_ready, 1'b1);
    chk("rst.out_valid", out_valid, 1'b0);
    chk("rst.valE", valE, 64'd0);
    chk("rst.cnd", cnd, 1'b0);
    chk("rst.err", err, 1'b0);
    chk("rst.cc", cc, 3'b001);
    chk("rst.alu_fn", alu_fn, 2'd0);
    chk("rst.alu_a", alu_a, 64'd0);
    chk("rst.alu_b", alu_b, 64'd0);

    run("subq", 4'h6, 4'h1, 64'd5, 64'd5, 64'd0, 1'b1, 2'd1, 64'd5, 64'd5,
        64'd0, 1'b0, 1'b0, 3'b001);
    run("addq_ovf", 4'h6, 4'h0, 64'd1, 64'h7FFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, 2'd0, 64'd1,
        64'h7FFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 1'b0, 1'b0, 3'b110);
    run("jl", 4'h7, 4'h2, 64'd0, 64'd0, 64'h40, 1'b1, 2'd0, 64'd0, 64'd0,
        64'd0, 1'b0, 1'b0, 3'b110);
    run("jle", 4'h7, 4'h1, 64'd0, 64'd0, 64'h40, 1'b1, 2'd0, 64'd0, 64'd0,
        64'd0, 1'b0, 1'b0, 3'b110);
    run("jne", 4'h7, 4'h4, 64'd0, 64'd0, 64'h40, 1'b1, 2'd0, 64'd0, 64'd0,
        64'd0, 1'b1, 1'b0, 3'b110);
    run("rrmovq", 4'h2, 4'h0, 64'h77, 64'h99, 64'd0, 1'b1, 2'd0, 64'h77, 64'd0,
        64'h77, 1'b1, 1'b0, 3'b110);
    run("pushq", 4'hA, 4'h0, 64'd3, 64'h100, 64'd0, 1'b1, 2'd1, 64'd8, 64'h100,
        64'hF8, 1'b0, 1'b0, 3'b110);
    run("popq_wrap", 4'hB, 4'h0, 64'd3, 64'hFFFF_FFFF_FFFF_FFF8, 64'd0, 1'b1, 2'd0, 64'd8,
        64'hFFFF_FFFF_FFFF_FFF8, 64'd0, 1'b0, 1'b0, 3'b110);
    run("rmmovq", 4'h4, 4'h0, 64'd1, 64'h20, 64'h10, 1'b1, 2'd0, 64'h10, 64'h20,
        64'h30, 1'b0, 1'b0, 3'b110);
    run("andq", 4'h6, 4'h2, 64'hFF00, 64'h0FF0, 64'd0, 1'b1, 2'd2, 64'hFF00, 64'h0FF0,
        64'h0F00, 1'b0, 1'b0, 3'b000);

    // Back-pressure: hold out_ready low in RESP while decode keeps offering
    out_ready = 1'b0;
    icode = 4'h3; ifun = 4'h0; valA = 64'd0; valB = 64'd0; valC = 64'h1234; in_valid = 1'b1;
    tick();
    icode = 4'h6; ifun = 4'h0; valA = 64'd9; valB = 64'd9;
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("stall.out_valid", out_valid, 1'b1);
      chk("stall.valE", valE, 64'h1234);
      chk("stall.cnd", cnd, 1'b0);
      chk("stall.in_ready", in_ready, 1'b0);
      tick();
    end
    chk("stall.cc", cc, 3'b000);
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("release.in_ready", in_ready, 1'b1);
    chk("release.out_valid", out_valid, 1'b0);
    tick();
    chk("release.no_accept", out_valid, 1'b0);
    chk("release.valE_kept", valE, 64'h1234);

    run("bad_icode", 4'hC, 4'h0, 64'd1, 64'd2, 64'd3, 1'b0, 2'd0, 64'd0, 64'd0,
        64'd0, 1'b0, 1'b1, 3'b000);
    run("bad_opq", 4'h6, 4'h5, 64'd0, 64'd0, 64'd0, 1'b0, 2'd0, 64'd0, 64'd0,
        64'd0, 1'b0, 1'b1, 3'b000);
    run("bad_cmov", 4'h2, 4'h7, 64'h55, 64'd0, 64'd0, 1'b0, 2'd0, 64'd0, 64'd0,
        64'd0, 1'b0, 1'b1, 3'b000);
    run("ok_after_err", 4'h3, 4'h0, 64'd0, 64'd0, 64'h5A, 1'b1, 2'd0, 64'h5A, 64'd0,
        64'h5A, 1'b0, 1'b0, 3'b000);

    // Reset while an OPq (1+1, ZF=0) sits in EXEC
    icode = 4'h6; ifun = 4'h0; valA = 64'd1; valB = 64'd1; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("rstx.in_exec", in_ready, 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rstx.in_ready", in_ready, 1'b1);
    chk("rstx.out_valid", out_valid, 1'b0);
    chk("rstx.cc", cc, 3'b001);
    chk("rstx.valE", valE, 64'd0);
    tick();
    chk("rstx.stays_idle", out_valid, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
